// File: rtl/freq_scorer.sv
// rtl/freq_scorer.sv - pops song/reference FIFOs in lockstep, counts tolerance hits and divides for a percentage score
module freq_scorer #(
    parameter int FREQ_W = 15,
    parameter int CNT_W  = 12,
    parameter int TOL    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FREQ_W-1:0] song_dout,
    input  logic              song_valid,
    input  logic              song_empty,
    input  logic [FREQ_W-1:0] ref_dout,
    input  logic              ref_valid,
    input  logic              ref_empty,
    output logic              rd_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hits,
    output logic [CNT_W-1:0]  total,
    output logic [6:0]        score_pct,
    output logic              err
);

    localparam int NUM_W = CNT_W + 7;
    localparam int IT_W  = $clog2(NUM_W);
    localparam logic [FREQ_W:0]  TOL_V   = (FREQ_W + 1)'(TOL);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [IT_W-1:0]  IT_LAST = IT_W'(NUM_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CMP,
        S_DIV_INIT,
        S_DIV_RUN,
        S_DONE
    } state_t;

    state_t state, state_next;
    logic   accept;

    logic signed [FREQ_W:0] diff;
    logic [FREQ_W:0]        abs_diff;
    logic                   is_hit;

    logic [NUM_W-1:0] quo, quo_next, numer;
    logic [CNT_W-1:0] rem, rem_next;
    logic [CNT_W:0]   trial, sub;
    logic             ge;
    logic [IT_W-1:0]  iter;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_next = S_READ;
            S_READ:         state_next = (!song_empty && !ref_empty) ? S_CMP : S_DIV_INIT;
            S_CMP:          state_next = (song_valid && ref_valid) ? S_READ : S_DIV_INIT;
            S_DIV_INIT:     state_next = (total == '0) ? S_DONE : S_DIV_RUN;
            S_DIV_RUN:      if (iter == IT_LAST) state_next = S_DONE;
            default:        state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        accept = 1'b0;
        case (state)
            S_IDLE: accept = start;
            S_DONE: begin
                done   = 1'b1;
                accept = start;
            end
            S_READ: begin
                busy  = 1'b1;
                rd_en = !song_empty && !ref_empty;
            end
            S_CMP, S_DIV_INIT, S_DIV_RUN: busy = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        diff     = $signed({1'b0, song_dout}) - $signed({1'b0, ref_dout});
        abs_diff = diff[FREQ_W] ? $unsigned(-diff) : $unsigned(diff);
        is_hit   = abs_diff <= TOL_V;
    end

    // hits*100 = hits*64 + hits*32 + hits*4
    assign numer = ({7'b0, hits} << 6) + ({7'b0, hits} << 5) + ({7'b0, hits} << 2);

    // rem < total, so the sign of (trial - total) in CNT_W+1 bits is a valid compare
    always_comb begin
        trial    = {rem, quo[NUM_W-1]};
        sub      = trial - {1'b0, total};
        ge       = ~sub[CNT_W];
        rem_next = ge ? sub[CNT_W-1:0] : {rem[CNT_W-2:0], quo[NUM_W-1]};
        quo_next = {quo[NUM_W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hits      <= '0;
            total     <= '0;
            score_pct <= '0;
            err       <= 1'b0;
            quo       <= '0;
            rem       <= '0;
            iter      <= '0;
        end else begin
            if (accept) begin
                hits      <= '0;
                total     <= '0;
                score_pct <= '0;
                err       <= 1'b0;
            end
            case (state)
                S_READ: begin
                    if (song_empty != ref_empty) err <= 1'b1;
                end
                S_CMP: begin
                    if (!(song_valid && ref_valid)) begin
                        err <= 1'b1;
                    end else if (ref_dout != '0) begin
                        if (total != CNT_MAX) total <= total + CNT_W'(1);
                        if (is_hit && hits != CNT_MAX) hits <= hits + CNT_W'(1);
                    end
                end
                S_DIV_INIT: begin
                    if (total == '0) begin
                        score_pct <= '0;
                    end else begin
                        quo  <= numer;
                        rem  <= '0;
                        iter <= '0;
                    end
                end
                S_DIV_RUN: begin
                    quo  <= quo_next;
                    rem  <= rem_next;
                    iter <= iter + IT_W'(1);
                    if (iter == IT_LAST) score_pct <= quo_next[6:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_scorer.sv
// tb/tb_freq_scorer.sv - directed bench for freq_scorer with a behavioural FIFO pair
module tb_freq_scorer;

    localparam int FREQ_W = 15;
    localparam int CNT_W  = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [FREQ_W-1:0] song_dout = '0;
    logic              song_valid = 1'b0;
    logic              song_empty;
    logic [FREQ_W-1:0] ref_dout = '0;
    logic              ref_valid = 1'b0;
    logic              ref_empty;
    logic              rd_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  hits;
    logic [CNT_W-1:0]  total;
    logic [6:0]        score_pct;
    logic              err;

    freq_scorer #(.FREQ_W(FREQ_W), .CNT_W(CNT_W), .TOL(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .song_dout(song_dout), .song_valid(song_valid), .song_empty(song_empty),
        .ref_dout(ref_dout), .ref_valid(ref_valid), .ref_empty(ref_empty),
        .rd_en(rd_en), .busy(busy), .done(done),
        .hits(hits), .total(total), .score_pct(score_pct), .err(err)
    );

    always #5 clk = ~clk;

    logic [FREQ_W-1:0] song_mem [0:127];
    logic [FREQ_W-1:0] ref_mem  [0:127];
    int   song_wp = 0, song_rp = 0, ref_wp = 0, ref_rp = 0;
    logic flush = 1'b0;

    assign song_empty = (song_wp == song_rp);
    assign ref_empty  = (ref_wp == ref_rp);

    always @(posedge clk) begin
        song_valid <= 1'b0;
        ref_valid  <= 1'b0;
        if (flush) begin
            song_rp <= song_wp;
            ref_rp  <= ref_wp;
        end else if (rd_en) begin
            if (!song_empty) begin
                song_dout  <= song_mem[song_rp];
                song_valid <= 1'b1;
                song_rp    <= song_rp + 1;
            end
            if (!ref_empty) begin
                ref_dout  <= ref_mem[ref_rp];
                ref_valid <= 1'b1;
                ref_rp    <= ref_rp + 1;
            end
        end
    end

    int   rd_cnt = 0, b2b_cnt = 0;
    logic rd_prev = 1'b0;
    always @(posedge clk) begin
        if (rd_en) begin
            rd_cnt = rd_cnt + 1;
            if (rd_prev) b2b_cnt = b2b_cnt + 1;
        end
        rd_prev = rd_en;
    end

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_song(input int s);
        song_mem[song_wp] = FREQ_W'(s);
        song_wp++;
    endtask

    task automatic push_ref(input int r);
        ref_mem[ref_wp] = FREQ_W'(r);
        ref_wp++;
    endtask

    task automatic push_pair(input int s, input int r);
        push_song(s);
        push_ref(r);
    endtask

    task automatic do_flush();
        @(negedge clk) flush = 1'b1;
        @(negedge clk) flush = 1'b0;
    endtask

    // Pulses start, optionally re-pulses it at cycles x1/x2, returns cycles until done.
    task automatic run_score(input int x1, input int x2, output int lat, output int rds, output int b2b);
        int rd0, b0;
        rd0 = rd_cnt;
        b0  = b2b_cnt;
        lat = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            start = (k == x1 || k == x2);
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        rds = rd_cnt - rd0;
        b2b = b2b_cnt - b0;
        check("done_timeout", (lat > 0), 1);
    endtask

    task automatic check_results(input string tag, input int t, input int h, input int p, input int e);
        check({tag, "_total"}, total, t);
        check({tag, "_hits"}, hits, h);
        check({tag, "_pct"}, score_pct, p);
        check({tag, "_err"}, err, e);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_hits"}, hits, 0);
        check({tag, "_total"}, total, 0);
        check({tag, "_pct"}, score_pct, 0);
        check({tag, "_err"}, err, 0);
    endtask

    int lat, rds, b2b;

    initial begin
        rst = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check_idle_zero("reset");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", busy, 0);

        push_pair(440, 440);
        push_pair(445, 440);
        push_pair(500, 440);
        push_pair(262, 262);
        run_score(-1, -1, lat, rds, b2b);
        check("basic_rd", rds, 4);
        check("basic_b2b", b2b, 0);
        check("basic_lat", lat, 29);
        check_results("basic", 4, 3, 75, 0);

        push_pair(0, 0);
        push_pair(300, 0);
        push_pair(330, 330);
        run_score(-1, -1, lat, rds, b2b);
        check("rest_rd", rds, 3);
        check_results("rest", 1, 1, 100, 0);

        run_score(-1, -1, lat, rds, b2b);
        check("empty_rd", rds, 0);
        check("empty_lat", lat, 2);
        check_results("empty", 0, 0, 0, 0);

        push_pair(100, 100);
        push_pair(200, 250);
        push_song(300);
        run_score(-1, -1, lat, rds, b2b);
        check("desync_rd", rds, 2);
        check("desync_song_left", song_wp - song_rp, 1);
        check("desync_done", done, 1);
        check_results("desync", 2, 1, 50, 1);
        do_flush();

        push_pair(448, 440);
        run_score(-1, -1, lat, rds, b2b);
        check_results("tol_eq", 1, 1, 100, 0);
        push_pair(449, 440);
        run_score(-1, -1, lat, rds, b2b);
        check_results("tol_p1", 1, 0, 0, 0);

        push_pair(448, 440);
        push_pair(449, 440);
        push_pair(0, 440);
        push_pair(432, 440);
        push_pair(431, 440);
        push_pair(1000, 1000);
        push_pair(20000, 100);
        run_score(-1, -1, lat, rds, b2b);
        check_results("floor", 7, 3, 42, 0);

        push_pair(440, 440);
        push_pair(445, 440);
        push_pair(500, 440);
        push_pair(262, 262);
        run_score(2, 15, lat, rds, b2b);
        check("ignore_lat", lat, 29);
        check("ignore_rd", rds, 4);
        check_results("ignore", 4, 3, 75, 0);

        push_pair(440, 440);
        push_pair(445, 440);
        push_pair(500, 440);
        push_pair(262, 262);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (14) @(negedge clk);
        check("middiv_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("middiv_rst");
        @(negedge clk);
        check("middiv_stay_idle", busy, 0);

        do_flush();
        push_pair(330, 330);
        push_pair(340, 330);
        run_score(-1, -1, lat, rds, b2b);
        check("fresh_lat", lat, 25);
        check_results("fresh", 2, 1, 50, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
